// File: rtl/dfm_reg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : dfm_reg_bank_if
//  Purpose  : Write / commit / read bus bundle for the frequency-meter register bank.
//  Revision : 1.0  initial release
// ============================================================================
interface dfm_reg_bank_if #(
    parameter int DW     = 8,
    parameter int NUM_RW = 8,
    parameter int AW     = 4
);
    logic                 bulk_wr_en_i;
    logic [NUM_RW*DW-1:0] bulk_wr_data_i;
    logic                 byte_wr_en_i;
    logic [AW-1:0]        byte_wr_addr_i;
    logic [DW-1:0]        byte_wr_data_i;
    logic                 wr_err_o;
    logic                 commit_i;
    logic                 commit_done_o;
    logic                 rd_en_i;
    logic                 rd_req_i;
    logic [AW-1:0]        rd_addr_i;
    logic [DW-1:0]        rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_err_o;
    logic [NUM_RW*DW-1:0] cfg_o;

    modport master (
        output bulk_wr_en_i, bulk_wr_data_i, byte_wr_en_i, byte_wr_addr_i, byte_wr_data_i,
        output commit_i, rd_en_i, rd_req_i, rd_addr_i,
        input  wr_err_o, commit_done_o, rd_data_o, rd_valid_o, rd_err_o, cfg_o
    );

    modport slave (
        input  bulk_wr_en_i, bulk_wr_data_i, byte_wr_en_i, byte_wr_addr_i, byte_wr_data_i,
        input  commit_i, rd_en_i, rd_req_i, rd_addr_i,
        output wr_err_o, commit_done_o, rd_data_o, rd_valid_o, rd_err_o, cfg_o
    );
endinterface
`default_nettype wire

// File: rtl/dfm_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : dfm_reg_bank
//  Purpose  : Byte-addressed RO/staging/active register bank with read-burst-safe commit.
//  Revision : 1.0  initial release
// ============================================================================
module dfm_reg_bank #(
    parameter int                     DW      = 8,
    parameter int                     NUM_RO  = 8,
    parameter int                     NUM_RW  = 8,
    parameter int                     AW      = 4,
    parameter logic [NUM_RO*DW-1:0]   RO_INIT = '0
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    dfm_reg_bank_if.slave    bus
);
    localparam int         c_NUM_ADDR = 2**AW;
    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_PEND     = 1'b1;

    logic [NUM_RW*DW-1:0] r_staging;
    logic [NUM_RW*DW-1:0] r_active;
    logic [0:0]           r_state;
    logic                 r_commit_done;
    logic                 r_wr_err;
    logic [DW-1:0]        r_rd_data;
    logic                 r_rd_valid;
    logic                 r_rd_err;

    logic [NUM_RW-1:0]     w_byte_hit;
    logic                  w_copy;
    logic [DW-1:0]         w_map [c_NUM_ADDR];
    logic [c_NUM_ADDR-1:0] w_mapped;

    generate
        for (genvar j = 0; j < NUM_RW; j++) begin : g_hit
            localparam logic [AW-1:0] c_ADDR = AW'(NUM_RO + j);
            assign w_byte_hit[j] = bus.byte_wr_en_i && (bus.byte_wr_addr_i == c_ADDR);
        end

        // Flat read map over the whole address space; holes read as zero and flag an error.
        for (genvar k = 0; k < c_NUM_ADDR; k++) begin : g_map
            if (k < NUM_RO) begin : g_ro
                assign w_map[k]    = RO_INIT[k*DW +: DW];
                assign w_mapped[k] = 1'b1;
            end else if (k < NUM_RO + NUM_RW) begin : g_rw
                assign w_map[k]    = r_active[(k-NUM_RO)*DW +: DW];
                assign w_mapped[k] = 1'b1;
            end else begin : g_hole
                assign w_map[k]    = '0;
                assign w_mapped[k] = 1'b0;
            end
        end
    endgenerate

    // A copy happens whenever a request (new or parked) sees the read burst idle.
    assign w_copy = !bus.rd_en_i && ((r_state == c_PEND) || bus.commit_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_staging <= '0;
        end else begin
            for (int j = 0; j < NUM_RW; j++) begin
                if (w_byte_hit[j]) begin
                    r_staging[j*DW +: DW] <= bus.byte_wr_data_i;
                end else if (bus.bulk_wr_en_i) begin
                    r_staging[j*DW +: DW] <= bus.bulk_wr_data_i[j*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= c_IDLE;
            r_active      <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= w_copy;
            if (w_copy) begin
                r_state  <= c_IDLE;
                r_active <= r_staging;
            end else if (bus.commit_i) begin
                r_state  <= c_PEND;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_err   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_err   <= bus.byte_wr_en_i && !(|w_byte_hit);
            r_rd_valid <= bus.rd_req_i;
            r_rd_err   <= bus.rd_req_i && !w_mapped[bus.rd_addr_i];
            if (bus.rd_req_i) begin
                r_rd_data <= w_map[bus.rd_addr_i];
            end
        end
    end

    assign bus.wr_err_o      = r_wr_err;
    assign bus.commit_done_o = r_commit_done;
    assign bus.rd_data_o     = r_rd_data;
    assign bus.rd_valid_o    = r_rd_valid;
    assign bus.rd_err_o      = r_rd_err;
    assign bus.cfg_o         = r_active;
endmodule
`default_nettype wire

// File: tb/tb_dfm_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dfm_reg_bank
//  Purpose  : Directed and randomized self-checking bench for dfm_reg_bank.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dfm_reg_bank;
    localparam int                   DW      = 8;
    localparam int                   NUM_RO  = 4;
    localparam int                   NUM_RW  = 8;
    localparam int                   AW      = 4;
    localparam logic [NUM_RO*DW-1:0] RO_INIT = 32'h44332211;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dfm_reg_bank_if #(.DW(DW), .NUM_RW(NUM_RW), .AW(AW)) bus ();

    dfm_reg_bank #(
        .DW(DW), .NUM_RO(NUM_RO), .NUM_RW(NUM_RW), .AW(AW), .RO_INIT(RO_INIT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Behavioural model: staging/active byte arrays plus a "commit wanted" flag.
    logic [DW-1:0] m_stg [NUM_RW];
    logic [DW-1:0] m_act [NUM_RW];
    logic          m_pend;
    logic [DW-1:0] e_rd_data;
    logic          e_rd_valid, e_rd_err, e_wr_err, e_done;

    function automatic logic [DW-1:0] ro_byte(input int a);
        logic [NUM_RO*DW-1:0] v;
        v = RO_INIT;
        return v[a*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic [DW-1:0] n_stg [NUM_RW];
        logic [DW-1:0] n_act [NUM_RW];
        int ra, wa;
        logic want, bad_wr;
        if (!rst_n) begin
            for (int j = 0; j < NUM_RW; j++) begin
                m_stg[j] <= '0;
                m_act[j] <= '0;
            end
            m_pend     <= 1'b0;
            e_rd_data  <= '0;
            e_rd_valid <= 1'b0;
            e_rd_err   <= 1'b0;
            e_wr_err   <= 1'b0;
            e_done     <= 1'b0;
        end else begin
            ra     = int'(bus.rd_addr_i);
            wa     = int'(bus.byte_wr_addr_i);
            n_stg  = m_stg;
            n_act  = m_act;
            bad_wr = bus.byte_wr_en_i && (wa < NUM_RO || wa >= NUM_RO + NUM_RW);
            want   = m_pend || bus.commit_i;

            e_rd_valid <= bus.rd_req_i;
            e_rd_err   <= bus.rd_req_i && (ra >= NUM_RO + NUM_RW);
            if (bus.rd_req_i) begin
                if (ra < NUM_RO)                e_rd_data <= ro_byte(ra);
                else if (ra < NUM_RO + NUM_RW)  e_rd_data <= m_act[ra - NUM_RO];
                else                            e_rd_data <= '0;
            end
            e_wr_err <= bad_wr;
            e_done   <= want && !bus.rd_en_i;

            if (want && !bus.rd_en_i) begin
                n_act  = m_stg;
                m_pend <= 1'b0;
            end else begin
                m_pend <= want;
            end
            if (bus.bulk_wr_en_i)
                for (int j = 0; j < NUM_RW; j++) n_stg[j] = bus.bulk_wr_data_i[j*DW +: DW];
            if (bus.byte_wr_en_i && !bad_wr)
                n_stg[wa - NUM_RO] = bus.byte_wr_data_i;

            m_stg <= n_stg;
            m_act <= n_act;
        end
    end

    function automatic logic [63:0] model_cfg();
        logic [63:0] p;
        for (int j = 0; j < NUM_RW; j++) p[j*DW +: DW] = m_act[j];
        return p;
    endfunction

    always @(negedge clk) begin : compare
        check("rd_valid",    64'(bus.rd_valid_o),    64'(e_rd_valid));
        check("rd_err",      64'(bus.rd_err_o),      64'(e_rd_err));
        check("rd_data",     64'(bus.rd_data_o),     64'(e_rd_data));
        check("wr_err",      64'(bus.wr_err_o),      64'(e_wr_err));
        check("commit_done", 64'(bus.commit_done_o), 64'(e_done));
        check("cfg",         64'(bus.cfg_o),         model_cfg());
    end

    // Moves off the falling edge and clears all one-cycle strobes.
    task automatic clr();
        #1;
        bus.bulk_wr_en_i = 1'b0;
        bus.byte_wr_en_i = 1'b0;
        bus.commit_i     = 1'b0;
        bus.rd_req_i     = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.bulk_wr_en_i   = 1'b0;
        bus.bulk_wr_data_i = '0;
        bus.byte_wr_en_i   = 1'b0;
        bus.byte_wr_addr_i = '0;
        bus.byte_wr_data_i = '0;
        bus.commit_i       = 1'b0;
        bus.rd_en_i        = 1'b0;
        bus.rd_req_i       = 1'b0;
        bus.rd_addr_i      = '0;

        repeat (3) @(negedge clk);
        check("lit_reset_cfg",   64'(bus.cfg_o), 64'h0);
        check("lit_reset_valid", 64'(bus.rd_valid_o), 64'h0);
        clr(); rst_n = 1'b1;

        // RO read at address 0
        @(negedge clk);
        clr(); bus.rd_req_i = 1'b1; bus.rd_addr_i = 4'd0;
        @(negedge clk);
        check("lit_ro_data", 64'(bus.rd_data_o), 64'h11);
        check("lit_ro_err",  64'(bus.rd_err_o),  64'h0);

        // Bulk load then immediate commit
        clr(); bus.bulk_wr_en_i = 1'b1; bus.bulk_wr_data_i = 64'h0807060504030201;
        @(negedge clk);
        clr(); bus.commit_i = 1'b1;
        @(negedge clk);
        check("lit_done_now", 64'(bus.commit_done_o), 64'h1);
        check("lit_cfg_1",    64'(bus.cfg_o), 64'h0807060504030201);
        clr(); bus.rd_req_i = 1'b1; bus.rd_addr_i = 4'd5;
        @(negedge clk);
        check("lit_rw_read", 64'(bus.rd_data_o), 64'h02);
        check("lit_done_gone", 64'(bus.commit_done_o), 64'h0);

        // Commit parked behind a 5-cycle read burst
        clr(); bus.bulk_wr_en_i = 1'b1; bus.bulk_wr_data_i = 64'h1817161514131211;
        @(negedge clk);
        clr(); bus.rd_en_i = 1'b1; bus.commit_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            clr(); bus.rd_req_i = 1'b1; bus.rd_addr_i = 4'd4;
            if (i == 2) bus.commit_i = 1'b1;
            @(negedge clk);
            check("lit_pend_cfg",  64'(bus.cfg_o), 64'h0807060504030201);
            check("lit_pend_data", 64'(bus.rd_data_o), 64'h01);
        end
        clr(); bus.rd_en_i = 1'b0;
        @(negedge clk);
        check("lit_pend_done", 64'(bus.commit_done_o), 64'h1);
        check("lit_cfg_2",     64'(bus.cfg_o), 64'h1817161514131211);
        clr();
        @(negedge clk);
        check("lit_single_done", 64'(bus.commit_done_o), 64'h0);

        // Byte writes to RO and unmapped addresses are rejected
        clr(); bus.byte_wr_en_i = 1'b1; bus.byte_wr_addr_i = 4'd3; bus.byte_wr_data_i = 8'h55;
        @(negedge clk);
        check("lit_wr_err_ro", 64'(bus.wr_err_o), 64'h1);
        clr(); bus.byte_wr_en_i = 1'b1; bus.byte_wr_addr_i = 4'd13; bus.byte_wr_data_i = 8'h66;
        @(negedge clk);
        check("lit_wr_err_hole", 64'(bus.wr_err_o), 64'h1);
        clr(); bus.commit_i = 1'b1;
        @(negedge clk);
        check("lit_wr_err_clear", 64'(bus.wr_err_o), 64'h0);
        check("lit_stg_kept",     64'(bus.cfg_o), 64'h1817161514131211);

        // Bulk and byte in the same cycle: byte lands on top
        clr(); bus.bulk_wr_en_i = 1'b1; bus.bulk_wr_data_i = 64'h2827262524232221;
        bus.byte_wr_en_i = 1'b1; bus.byte_wr_addr_i = 4'd4; bus.byte_wr_data_i = 8'hAA;
        @(negedge clk);
        clr(); bus.commit_i = 1'b1;
        @(negedge clk);
        check("lit_byte_wins", 64'(bus.cfg_o), 64'h28272625242322AA);

        // Unmapped read
        clr(); bus.rd_req_i = 1'b1; bus.rd_addr_i = 4'd15;
        @(negedge clk);
        check("lit_hole_data",  64'(bus.rd_data_o),  64'h0);
        check("lit_hole_err",   64'(bus.rd_err_o),   64'h1);
        check("lit_hole_valid", 64'(bus.rd_valid_o), 64'h1);

        // Reset while a commit is parked
        clr(); bus.bulk_wr_en_i = 1'b1; bus.bulk_wr_data_i = 64'h3837363534333231;
        @(negedge clk);
        clr(); bus.rd_en_i = 1'b1; bus.commit_i = 1'b1;
        @(negedge clk);
        clr(); rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_cfg",  64'(bus.cfg_o), 64'h0);
        check("lit_rst_done", 64'(bus.commit_done_o), 64'h0);
        clr(); rst_n = 1'b1; bus.rd_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_post_rst_done", 64'(bus.commit_done_o), 64'h0);
            check("lit_post_rst_cfg",  64'(bus.cfg_o), 64'h0);
            clr();
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clr();
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) bus.rd_en_i = ~bus.rd_en_i;
            bus.bulk_wr_en_i   = ($urandom_range(0, 9) == 0);
            bus.bulk_wr_data_i = {$urandom, $urandom};
            bus.byte_wr_en_i   = ($urandom_range(0, 3) == 0);
            bus.byte_wr_addr_i = AW'($urandom_range(0, 15));
            bus.byte_wr_data_i = DW'($urandom);
            bus.commit_i       = ($urandom_range(0, 7) == 0);
            bus.rd_req_i       = ($urandom_range(0, 1) == 0);
            bus.rd_addr_i      = AW'($urandom_range(0, 15));
            @(negedge clk);
        end

        clr(); rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
